regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port general-purpose register file with write-through bypass, a per-register pending-write scoreboard and a sequential clear engine. It replaces the fixed 32×32, 2-read/1-write register file in the decode stage. Issue logic reads operands and their readiness here; writeback ports retire results here.

## Interface
Parameters:
- DW, 32, data width in bits
- AW, 5, address width; NREG = 2**AW registers
- NR, 2, number of read ports
- NW, 2, number of write ports; higher index has higher priority

Ports:
- clk  in  1  clock; single clock domain, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  NW  per-port write enable
- waddr  in  NW*AW  write addresses, port k at [k*AW +: AW]
- wdata  in  NW*DW  write data, port k at [k*DW +: DW]
- re  in  NR  per-port read enable
- raddr  in  NR*AW  read addresses
- rdata  out  NR*DW  read data, combinational
- rvalid  out  NR  operand ready (no outstanding producer, or bypassed this cycle)
- iss_valid  in  1  mark iss_addr pending
- iss_addr  in  AW  destination register of the issued instruction
- clr_req  in  1  start clear sweep (pulse)
- clr_busy  out  1  sweep in progress

## Operation
- Register 0: always reads 0, never written, never pending.
- Write: each port k with we[k]=1 and waddr≠0 updates regs[waddr] at posedge. Same address on several ports: highest-index port wins.
- Read port i, priority order: rst=1 → 0; raddr=0 → 0; re[i]=0 → 0; matches a live write (we=1, same addr) → wdata of highest-index matching port; else regs[raddr].
- rvalid[i] = 1 if raddr=0, re[i]=0, bypass hit, or pend[raddr]=0; else 0.
- Scoreboard pend[NREG-1:1]: iss_valid with iss_addr≠0 sets bit; any write port to addr clears bit. Set and clear of same address in same cycle: set wins (newer producer).
- Clear engine FSM, states IDLE, SWEEP:
  - IDLE: clr_req=1 → SWEEP, ptr=1.
  - SWEEP: each cycle regs[ptr]←0, pend[ptr]←0, ptr←ptr+1. When ptr=NREG-1, clear that register and go to IDLE.
  - clr_req while in SWEEP is ignored.
  - In SWEEP, we and iss_valid are ignored; the caller stalls on clr_busy.
  - Reads stay live in SWEEP and return partially cleared contents.
  - clr_busy = (state==SWEEP).

## Timing
- Read latency 0 (combinational). Write and scoreboard latency 1 cycle.
- Clear sweep: clr_busy high for exactly NREG-1 cycles starting the cycle after clr_req.
- Reset values: all regs 0, pend 0, state IDLE, ptr 0, clr_busy 0, rdata 0, rvalid all 1.
- rst asserted mid-sweep aborts the sweep immediately. After release the engine is IDLE.

## Structure
- Package regfile_pkg: state enum {IDLE, SWEEP} and default DW/AW/NR/NW constants.
- Sub-module regfile_rd_port: one read port's bypass mux plus rvalid logic, instantiated NR times via generate.
- Storage, scoreboard and FSM are in the top module.

## Test plan
- Reset then write r5=0xDEADBEEF on port 0 → next cycle raddr=5 reads 0xDEADBEEF; raddr=0 reads 0.
- Ports 0 and 1 both write r7 (0x11, 0x22) → bypass shows 0x22 that cycle; register holds 0x22 afterwards.
- iss r9, read r9 → rvalid=0. Next cycle write r9=0x55 → rvalid=1 with rdata 0x55 (bypass) that cycle; pend cleared after.
- iss r3 and write r3 in the same cycle → pend[3]=1 next cycle.
- Fill all registers, clr_req → clr_busy high 31 cycles (AW=5). Writes issued during the sweep are dropped. All reads return 0 afterwards.
- Assert rst at sweep cycle 10 → clr_busy=0 and all registers 0 immediately. After release a new clr_req is accepted.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the decode-stage register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int REG_DW = 32;
    localparam int REG_AW = 5;
    localparam int REG_NR = 2;
    localparam int REG_NW = 2;

    // Clear engine: either idle or stepping a pointer through the file
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One register-file read port: write-through bypass mux plus operand-ready flag.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; rvalid low tells issue logic the operand has an outstanding producer.
module regfile_rd_port #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NW = 2
) (
    input  logic             rst,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW*DW-1:0] wdata,
    input  logic [DW-1:0]    reg_dat,
    input  logic             pend_bit,
    output logic [DW-1:0]    rdata,
    output logic             rvalid
);

    logic          byp_hit;
    logic [DW-1:0] byp_dat;

    // Scan write ports low to high so the highest-index match wins the bypass
    always_comb begin
        byp_hit = 1'b0;
        byp_dat = '0;
        for (int k = 0; k < NW; k++) begin
            if (we[k] && (waddr[k*AW +: AW] == raddr)) begin
                byp_hit = 1'b1;
                byp_dat = wdata[k*DW +: DW];
            end
        end
    end

    // Result select: reset, r0 and disabled ports read as a ready zero
    always_comb begin
        rdata  = '0;
        rvalid = 1'b1;
        if (rst || (raddr == '0) || !re) begin
            rdata  = '0;
            rvalid = 1'b1;
        end else if (byp_hit) begin
            rdata  = byp_dat;
            rvalid = 1'b1;
        end else begin
            rdata  = reg_dat;
            rvalid = !pend_bit;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass, pending-write scoreboard and clear sweep.
// Latency: reads 0 cycles; writes and scoreboard updates visible after 1 cycle; sweep takes NREG-1 cycles.
// Backpressure: writes and issues are dropped while clr_busy is high; the caller must stall on it.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DW = REG_DW,
    parameter int AW = REG_AW,
    parameter int NR = REG_NR,
    parameter int NW = REG_NW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW*DW-1:0] wdata,
    input  logic [NR-1:0]    re,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    output logic [NR-1:0]    rvalid,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_addr,
    input  logic             clr_req,
    output logic             clr_busy
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0] regs [NREG];
    logic [NREG-1:0] pend;
    clr_state_t      state;
    logic [AW-1:0]   ptr;
    logic            busy_q;
    logic [NW-1:0]   we_eff;
    logic            iss_eff;

    // The sweep owns the storage; normal writes and issues are masked while it runs
    assign we_eff   = (state == SWEEP) ? '0 : we;
    assign iss_eff  = iss_valid && (state == IDLE) && (iss_addr != '0);
    assign clr_busy = busy_q;

    // Clear engine: walk ptr from 1 to NREG-1, one register per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state  <= SWEEP;
                        ptr    <= AW'(1);
                        busy_q <= 1'b1;
                    end
                end
                SWEEP: begin
                    ptr <= ptr + AW'(1);
                    if (&ptr) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage: sweep clears one entry, otherwise later write ports override earlier ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (state == SWEEP) begin
            regs[ptr] <= '0;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (we_eff[k] && (waddr[k*AW +: AW] != '0)) begin
                    regs[waddr[k*AW +: AW]] <= wdata[k*DW +: DW];
                end
            end
        end
    end

    // Scoreboard: writeback clears, issue sets last so a new producer outranks a retiring one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else if (state == SWEEP) begin
            pend[ptr] <= 1'b0;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (we_eff[k] && (waddr[k*AW +: AW] != '0)) begin
                    pend[waddr[k*AW +: AW]] <= 1'b0;
                end
            end
            if (iss_eff) begin
                pend[iss_addr] <= 1'b1;
            end
        end
    end

    // One bypass/ready unit per read port
    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = raddr[i*AW +: AW];

        regfile_rd_port #(
            .DW (DW),
            .AW (AW),
            .NW (NW)
        ) u_rd (
            .rst      (rst),
            .re       (re[i]),
            .raddr    (ra),
            .we       (we_eff),
            .waddr    (waddr),
            .wdata    (wdata),
            .reg_dat  (regs[ra]),
            .pend_bit (pend[ra]),
            .rdata    (rdata[i*DW +: DW]),
            .rvalid   (rvalid[i])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass, scoreboard, clear sweep and reset abort.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 1ns later.
// Backpressure: the bench holds off writes while clr_busy is high except where dropping them is the point.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic             clk;
    logic             rst;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rvalid;
    logic             iss_valid;
    logic [AW-1:0]    iss_addr;
    logic             clr_req;
    logic             clr_busy;

    int n_chk;
    int n_err;
    int cnt;

    regfile_sb #(
        .DW (DW),
        .AW (AW),
        .NR (NR),
        .NW (NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1ns past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes
    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] fill(input int r);
        return 32'hA500_0000 | 32'(r);
    endfunction

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[0] = 1'b1;
        waddr[AW-1:0] = a;
        wdata[DW-1:0] = d;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        we = '0;
        waddr = '0;
        wdata = '0;
        re = 2'b11;
        raddr = {5'd3, 5'd5};
        iss_valid = 1'b0;
        iss_addr = '0;
        clr_req = 1'b0;

        // Reset state
        tick();
        chk("rst_rdata0", rdata[31:0], 32'h0);
        chk("rst_rdata1", rdata[63:32], 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h3);
        chk("rst_busy", 32'(clr_busy), 32'h0);
        tick();
        rst = 1'b0;

        // Write r5 then read it back; r0 reads zero
        wr0(5'd5, 32'hDEADBEEF);
        tick();
        we = '0;
        raddr = {5'd0, 5'd5};
        settle();
        chk("r5_read", rdata[31:0], 32'hDEADBEEF);
        chk("r0_read", rdata[63:32], 32'h0);
        chk("r5_rvalid", 32'(rvalid), 32'h3);
        re = 2'b10;
        settle();
        chk("re_off_zero", rdata[31:0], 32'h0);
        re = 2'b11;

        // Both ports write r7: the higher port wins in bypass and storage
        we = 2'b11;
        waddr = {5'd7, 5'd7};
        wdata = {32'h22, 32'h11};
        raddr = {5'd0, 5'd7};
        settle();
        chk("r7_bypass", rdata[31:0], 32'h22);
        tick();
        we = '0;
        settle();
        chk("r7_stored", rdata[31:0], 32'h22);

        // Scoreboard: issue r9, then retire it through the bypass
        iss_valid = 1'b1;
        iss_addr = 5'd9;
        tick();
        iss_valid = 1'b0;
        raddr = {5'd0, 5'd9};
        settle();
        chk("r9_pending", 32'(rvalid[0]), 32'h0);
        wr0(5'd9, 32'h55);
        settle();
        chk("r9_byp_valid", 32'(rvalid[0]), 32'h1);
        chk("r9_byp_data", rdata[31:0], 32'h55);
        tick();
        we = '0;
        settle();
        chk("r9_cleared", 32'(rvalid[0]), 32'h1);
        chk("r9_stored", rdata[31:0], 32'h55);

        // Issue and write the same register in one cycle: the issue wins
        wr0(5'd3, 32'h33);
        iss_valid = 1'b1;
        iss_addr = 5'd3;
        tick();
        we = '0;
        iss_valid = 1'b0;
        raddr = {5'd0, 5'd3};
        settle();
        chk("r3_set_wins", 32'(rvalid[0]), 32'h0);
        chk("r3_data", rdata[31:0], 32'h33);
        wr0(5'd3, 32'h34);
        tick();
        we = '0;
        settle();
        chk("r3_retired", 32'(rvalid[0]), 32'h1);

        // Fill every register and leave r12 pending
        for (int r = 1; r < 32; r++) begin
            wr0(AW'(r), fill(r));
            tick();
        end
        we = '0;
        iss_valid = 1'b1;
        iss_addr = 5'd12;
        tick();
        iss_valid = 1'b0;
        raddr = {5'd12, 5'd31};
        settle();
        chk("fill_r31", rdata[31:0], fill(31));
        chk("fill_r12_pend", 32'(rvalid[1]), 32'h0);

        // Sweep, with writes and an issue hammered on throughout
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        we = 2'b11;
        waddr = {5'd31, 5'd2};
        wdata = {32'hFFFF, 32'hEEEE};
        iss_valid = 1'b1;
        iss_addr = 5'd20;
        raddr = {5'd2, 5'd31};
        settle();
        chk("sweep_busy", 32'(clr_busy), 32'h1);
        chk("sweep_no_byp", rdata[31:0], fill(31));
        cnt = 0;
        while (clr_busy && cnt < 100) begin
            if (cnt == 5) begin
                chk("sweep_r2_cleared", rdata[63:32], 32'h0);
                chk("sweep_r31_kept", rdata[31:0], fill(31));
            end
            cnt++;
            tick();
        end
        we = '0;
        iss_valid = 1'b0;
        chk("sweep_cycles", 32'(cnt), 32'd31);
        chk("sweep_done", 32'(clr_busy), 32'h0);
        for (int r = 0; r < 32; r++) begin
            raddr = {AW'(r), 5'd0};
            settle();
            chk($sformatf("post_sweep_r%0d", r), rdata[63:32], 32'h0);
            chk($sformatf("post_sweep_v%0d", r), 32'(rvalid[1]), 32'h1);
        end

        // Reset in the middle of a sweep aborts it and clears storage
        wr0(5'd30, 32'h30);
        tick();
        we = '0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt = 0;
        while (clr_busy && cnt < 10) begin
            cnt++;
            tick();
        end
        chk("abort_reached", 32'(cnt), 32'd10);
        rst = 1'b1;
        settle();
        chk("abort_busy", 32'(clr_busy), 32'h0);
        tick();
        rst = 1'b0;
        raddr = {5'd0, 5'd30};
        settle();
        chk("abort_r30_zero", rdata[31:0], 32'h0);
        chk("abort_idle", 32'(clr_busy), 32'h0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("restart_busy", 32'(clr_busy), 32'h1);
        cnt = 0;
        while (clr_busy && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("restart_cycles", 32'(cnt), 32'd31);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
